// File: rtl/fft_twiddle_gen.sv
// Twiddle-factor sequencer for a radix-2 DIF FFT: sweeps every stage/butterfly and
// streams packed {re, im} Q2.16 twiddles W_N^k over a valid/ready handshake.
module fft_twiddle_gen #(
  parameter int unsigned N_POINTS      = 64,
  parameter int unsigned SIZE_OF_CONST = 36,
  localparam int unsigned LOG2N        = $clog2(N_POINTS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     inverse_i,
  output logic [SIZE_OF_CONST-1:0] w_o,
  output logic                     w_valid_o,
  input  logic                     w_ready_i,
  output logic [LOG2N-1:0]         stage_o,
  output logic [LOG2N-2:0]         bfly_o,
  output logic                     w_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned HALF_W = SIZE_OF_CONST / 2;
  localparam int unsigned NHALF  = N_POINTS / 2;
  localparam int unsigned BW     = LOG2N - 1;
  localparam real         PI     = 3.14159265358979323846;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Round to nearest, ties away from zero.
  function automatic int round_haz(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  logic signed [HALF_W-1:0] rom_re [NHALF];
  logic signed [HALF_W-1:0] rom_im [NHALF];

  // Twiddle table W_N^k = cos(2pi k/N) - j sin(2pi k/N), folded to constants at elaboration.
  for (genvar gk = 0; gk < NHALF; gk++) begin : g_rom
    assign rom_re[gk] = HALF_W'(round_haz(65536.0 * $cos(2.0 * PI * real'(gk) / real'(N_POINTS))));
    assign rom_im[gk] = HALF_W'(round_haz(-65536.0 * $sin(2.0 * PI * real'(gk) / real'(N_POINTS))));
  end

  logic [1:0]               state_q, state_d;
  logic                     inv_q, inv_d;
  logic [LOG2N-1:0]         cnt_stage_q, cnt_stage_d;
  logic [BW-1:0]            cnt_bfly_q, cnt_bfly_d;
  logic                     all_loaded_q, all_loaded_d;
  logic [SIZE_OF_CONST-1:0] w_q, w_d;
  logic                     valid_q, valid_d;
  logic [LOG2N-1:0]         stage_q, stage_d;
  logic [BW-1:0]            bfly_q, bfly_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [LOG2N-1:0]         span_mask_c;
  logic [LOG2N-1:0]         masked_c;
  logic [BW-1:0]            addr_c;
  logic signed [HALF_W-1:0] im_c;
  logic [SIZE_OF_CONST-1:0] rom_word_c;
  logic                     last_pos_c;
  logic                     load_c;

  // Exponent k = (bfly mod (N/2 >> stage)) << stage, from the registered counters.
  assign span_mask_c = (LOG2N'(NHALF) >> cnt_stage_q) - LOG2N'(1);
  assign masked_c    = LOG2N'(cnt_bfly_q) & span_mask_c;
  assign addr_c      = BW'(masked_c << cnt_stage_q);
  assign im_c        = inv_q ? -rom_im[addr_c] : rom_im[addr_c];
  assign rom_word_c  = {rom_re[addr_c], im_c};
  assign last_pos_c  = (cnt_stage_q == LOG2N'(LOG2N - 1)) && (cnt_bfly_q == BW'(NHALF - 1));
  assign load_c      = !valid_q || w_ready_i;

  always_comb begin
    state_d      = state_q;
    inv_d        = inv_q;
    cnt_stage_d  = cnt_stage_q;
    cnt_bfly_d   = cnt_bfly_q;
    all_loaded_d = all_loaded_q;
    w_d          = w_q;
    valid_d      = valid_q;
    stage_d      = stage_q;
    bfly_d       = bfly_q;
    last_d       = last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (start_i) begin
          inv_d        = inverse_i;
          cnt_stage_d  = '0;
          cnt_bfly_d   = '0;
          all_loaded_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (load_c) begin
          if (!all_loaded_q) begin
            w_d     = rom_word_c;
            stage_d = cnt_stage_q;
            bfly_d  = cnt_bfly_q;
            last_d  = last_pos_c;
            valid_d = 1'b1;
            if (last_pos_c) begin
              all_loaded_d = 1'b1;
            end else if (cnt_bfly_q == BW'(NHALF - 1)) begin
              cnt_bfly_d  = '0;
              cnt_stage_d = cnt_stage_q + LOG2N'(1);
            end else begin
              cnt_bfly_d = cnt_bfly_q + BW'(1);
            end
          end else begin
            // Final word just accepted: drain and report completion.
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (valid_q) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      inv_q        <= 1'b0;
      cnt_stage_q  <= '0;
      cnt_bfly_q   <= '0;
      all_loaded_q <= 1'b0;
      w_q          <= '0;
      valid_q      <= 1'b0;
      stage_q      <= '0;
      bfly_q       <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      inv_q        <= inv_d;
      cnt_stage_q  <= cnt_stage_d;
      cnt_bfly_q   <= cnt_bfly_d;
      all_loaded_q <= all_loaded_d;
      w_q          <= w_d;
      valid_q      <= valid_d;
      stage_q      <= stage_d;
      bfly_q       <= bfly_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign w_o       = w_q;
  assign w_valid_o = valid_q;
  assign stage_o   = stage_q;
  assign bfly_o    = bfly_q;
  assign w_last_o  = last_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Bench for fft_twiddle_gen: N=8 and N=64 instances checked every cycle against a
// behavioural twiddle-sequence model plus hand-computed literal twiddles.
module tb_fft_twiddle_gen;

  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst;

  logic        start8, inv8, ready8, valid8, last8, busy8, done8;
  logic [35:0] w8;
  logic [2:0]  stage8;
  logic [1:0]  bfly8;

  logic        start64, inv64, ready64, valid64, last64, busy64, done64;
  logic [35:0] w64;
  logic [5:0]  stage64;
  logic [4:0]  bfly64;

  fft_twiddle_gen #(.N_POINTS(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .inverse_i(inv8),
    .w_o(w8), .w_valid_o(valid8), .w_ready_i(ready8), .stage_o(stage8),
    .bfly_o(bfly8), .w_last_o(last8), .busy_o(busy8), .done_o(done8)
  );

  fft_twiddle_gen #(.N_POINTS(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .inverse_i(inv64),
    .w_o(w64), .w_valid_o(valid64), .w_ready_i(ready64), .stage_o(stage64),
    .bfly_o(bfly64), .w_last_o(last64), .busy_o(busy64), .done_o(done64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          idx_a    [2];
  int          acc_a    [2];
  bit          post_rst [2];
  bit          exp_done [2];
  bit          stall    [2];
  bit          exp_inv  [2];
  logic [35:0] hold_w   [2];
  int          hold_st  [2];
  int          hold_bf  [2];
  bit          hold_last[2];

  // Hand-computed N=8 sequence of k and the four distinct table entries.
  int kseq8  [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  int lit_re [4]  = '{65536, 46341, 0, -46341};
  int lit_im [4]  = '{0, -46341, -65536, -46341};

  int rmode = 0;
  int pat   = 0;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic logic [35:0] lit(input int re, input int im, input bit inv);
    logic [17:0] r;
    logic [17:0] i;
    r = 18'(re);
    i = 18'(inv ? -im : im);
    return {r, i};
  endfunction

  // Word number idx of a sweep: its stage, butterfly, twiddle and last flag.
  function automatic void model(input int n, input int idx, input bit inv,
                                output logic [35:0] w, output int st, output int bf,
                                output bit last);
    int half, span, k, re, im;
    real a;
    half = n / 2;
    st   = idx / half;
    bf   = idx % half;
    span = half >> st;
    k    = (bf % span) << st;
    a    = 2.0 * PI * real'(k) / real'(n);
    re   = rnd(65536.0 * $cos(a));
    im   = rnd(-65536.0 * $sin(a));
    w    = lit(re, im, inv);
    last = (idx == $clog2(n) * half - 1);
  endfunction

  task automatic chk(input int u, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s at word %0d: actual %0h required %0h", u, nm, idx_a[u], act, exp);
    end
  endtask

  task automatic mon(input int u, input int n, input bit r, input bit valid, input bit ready,
                     input logic [35:0] w, input int st, input int bf, input bit last,
                     input bit busy, input bit done);
    logic [35:0] ew;
    int es, eb;
    bit el;
    el = 1'b0;
    if (post_rst[u]) begin
      chk(u, "rst_valid", 64'(valid), 0);
      chk(u, "rst_flags", {last, busy, done}, 0);
      chk(u, "rst_w", w, 0);
      chk(u, "rst_stage", st, 0);
      chk(u, "rst_bfly", bf, 0);
      post_rst[u] = 1'b0;
    end else begin
      chk(u, "done", 64'(done), 64'(exp_done[u]));
      if (exp_done[u]) begin
        chk(u, "done_busy", 64'(busy), 0);
        chk(u, "done_valid", 64'(valid), 0);
      end
      if (stall[u]) begin
        chk(u, "hold_valid", 64'(valid), 1);
        chk(u, "hold_w", w, hold_w[u]);
        chk(u, "hold_stage", st, hold_st[u]);
        chk(u, "hold_bfly", bf, hold_bf[u]);
        chk(u, "hold_last", 64'(last), 64'(hold_last[u]));
      end
      if (valid) begin
        model(n, idx_a[u], exp_inv[u], ew, es, eb, el);
        chk(u, "w", w, ew);
        chk(u, "stage", st, es);
        chk(u, "bfly", bf, eb);
        chk(u, "last", 64'(last), 64'(el));
        chk(u, "busy", 64'(busy), 1);
        if (n == 8 && idx_a[u] < 12)
          chk(u, "lit8", w, lit(lit_re[kseq8[idx_a[u]]], lit_im[kseq8[idx_a[u]]], exp_inv[u]));
        if (n == 64 && idx_a[u] == 8)
          chk(u, "lit64_k8", w, lit(46341, -46341, exp_inv[u]));
        if (n == 64 && idx_a[u] == 16)
          chk(u, "lit64_k16", w, lit(0, -65536, exp_inv[u]));
        if (n == 64 && idx_a[u] >= 160 && idx_a[u] < 192)
          chk(u, "lit64_stage5", w, lit(65536, 0, exp_inv[u]));
      end else begin
        chk(u, "last_idle", 64'(last), 0);
      end
      exp_done[u]  = valid && ready && el;
      stall[u]     = valid && !ready;
      hold_w[u]    = w;
      hold_st[u]   = st;
      hold_bf[u]   = bf;
      hold_last[u] = last;
      if (valid && ready) begin
        acc_a[u]++;
        idx_a[u] = el ? 0 : idx_a[u] + 1;
      end
    end
    if (r) begin
      post_rst[u] = 1'b1;
      idx_a[u]    = 0;
      exp_done[u] = 1'b0;
      stall[u]    = 1'b0;
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    mon(0, 8, rst, valid8, ready8, w8, 32'(stage8), 32'(bfly8), last8, busy8, done8);
    mon(1, 64, rst, valid64, ready64, w64, 32'(stage64), 32'(bfly64), last64, busy64, done64);
  end

  // Ready driver for the N=8 instance: always, 1-0-0-1 pattern, or random.
  always @(posedge clk) begin
    #1;
    pat = pat + 1;
    case (rmode)
      1:       ready8 = ((pat % 4) == 0) || ((pat % 4) == 3);
      2:       ready8 = ($urandom_range(0, 3) != 0);
      default: ready8 = 1'b1;
    endcase
  end

  task automatic start_sweep(input int u, input bit inv);
    @(posedge clk); #1;
    if (u == 0) begin start8 = 1'b1; inv8 = inv; end
    else begin start64 = 1'b1; inv64 = inv; end
    exp_inv[u] = inv;
    acc_a[u]   = 0;
    @(posedge clk); #1;
    start8 = 1'b0; inv8 = 1'b0; start64 = 1'b0; inv64 = 1'b0;
  endtask

  task automatic check_latency();
    @(negedge clk);
    chk(0, "lat_not_yet_valid", 64'(valid8), 0);
    chk(0, "lat_busy", 64'(busy8), 1);
    @(negedge clk);
    chk(0, "lat_first_valid", 64'(valid8), 1);
  endtask

  task automatic wait_done(input int u, input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if ((u == 0) ? done8 : done64) seen = 1'b1;
    end
    if (!seen) chk(u, "done_timeout", 0, 1);
  endtask

  task automatic wait_acc(input int u, input int n, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (acc_a[u] >= n) seen = 1'b1;
    end
    if (!seen) chk(u, "acc_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    bit rinv;
    rst = 1'b1; start8 = 1'b0; inv8 = 1'b0; ready8 = 1'b1;
    start64 = 1'b0; inv64 = 1'b0; ready64 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Forward and inverse sweeps, ready held high.
    rmode = 0;
    start_sweep(0, 1'b0);
    check_latency();
    wait_done(0, 100, cyc);
    chk(0, "fwd_count", acc_a[0], 12);
    start_sweep(0, 1'b1);
    check_latency();
    wait_done(0, 100, cyc);
    chk(0, "inv_count", acc_a[0], 12);

    // Backpressure 1-0-0-1.
    rmode = 1;
    start_sweep(0, 1'b0);
    wait_done(0, 200, cyc);
    chk(0, "bp_count", acc_a[0], 12);
    rmode = 0;

    // start_i re-pulsed mid-sweep is ignored.
    start_sweep(0, 1'b0);
    wait_acc(0, 5, 100);
    @(posedge clk); #1 start8 = 1'b1; inv8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0; inv8 = 1'b0;
    wait_done(0, 100, cyc);
    chk(0, "restart_count", acc_a[0], 12);
    repeat (4) begin
      @(negedge clk);
      chk(0, "no_second_sweep", {valid8, busy8}, 0);
    end

    // Reset mid-sweep aborts without done.
    start_sweep(0, 1'b0);
    wait_acc(0, 7, 100);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk(0, "abort_no_done", 64'(done8), 0);
    end
    start_sweep(0, 1'b1);
    check_latency();
    wait_done(0, 100, cyc);
    chk(0, "post_rst_count", acc_a[0], 12);

    // Random backpressure and direction.
    rmode = 2;
    for (int r = 0; r < 4; r++) begin
      rinv = 1'($urandom_range(0, 1));
      start_sweep(0, rinv);
      wait_done(0, 300, cyc);
      chk(0, "rand_count", acc_a[0], 12);
    end
    rmode = 0;

    // N=64 back-to-back sweep.
    start_sweep(1, 1'b0);
    wait_done(1, 400, cyc);
    chk(1, "n64_cycles", cyc, 194);
    chk(1, "n64_count", acc_a[1], 192);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
